// File: rtl/latent_grant_responder_pkg.sv
// Shared issue-path constants: parameter defaults and credit-count width
// for the latent grant responder and its arbiter.
package latent_grant_responder_pkg;

    localparam int unsigned DEF_N         = 8;
    localparam int unsigned DEF_P         = 2;
    localparam int unsigned DEF_GRANT_LAT = 2;
    localparam int unsigned DEF_CREDITS   = 2;
    localparam int unsigned CNT_W         = 3;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latent_grant_responder_rr_pick.sv
// Round-robin picker: grants the first requester found scanning upward
// from ptr, wrapping modulo P. Purely combinational.
module rr_pick
    import latent_grant_responder_pkg::*;
#(
    parameter int unsigned P     = DEF_P,
    parameter int unsigned PTR_W = idx_width(P)
) (
    input  logic [P-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [P-1:0]     win,
    output logic             any
);

    logic [PTR_W-1:0] idx;

    // Scan from ptr and keep only the first requester seen.
    always_comb begin
        win = '0;
        idx = '0;
        for (int unsigned i = 0; i < P; i++) begin
            idx = PTR_W'((32'(ptr) + i) % P);
            if (win == '0 && req[idx]) begin
                win[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/latent_grant_responder.sv
// Credit-limited request acceptor: picks one eligible port per cycle,
// holds it in flight, and pulses its grant a fixed latency later.
module latent_grant_responder
    import latent_grant_responder_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned P         = DEF_P,
    parameter int unsigned GRANT_LAT = DEF_GRANT_LAT,
    parameter int unsigned CREDITS   = DEF_CREDITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P-1:0]     req_vld,
    input  logic [P*N-1:0]   req_pick,
    input  logic             op_done,
    output logic [P-1:0]     grant,
    output logic [N-1:0]     grant_pick,
    output logic [CNT_W-1:0] credit_cnt
);

    localparam int unsigned      IDX_W    = idx_width(P);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    logic [IDX_W-1:0]     rr_ptr;
    logic [P-1:0]         in_flight;
    logic [P-1:0]         eligible;
    logic [P-1:0]         win;
    logic                 accept;
    logic [IDX_W-1:0]     win_idx;
    logic [N-1:0]         accept_pick;
    logic [CNT_W-1:0]     cnt_q;
    logic                 credit_ret;
    logic [GRANT_LAT-1:0] pipe_vld;
    logic [IDX_W-1:0]     pipe_idx  [GRANT_LAT];
    logic [N-1:0]         pipe_pick [GRANT_LAT];
    logic [P-1:0]         grant_raw;

    assign eligible = req_vld & ~in_flight & {P{cnt_q != '0}};

    rr_pick #(
        .P     (P),
        .PTR_W (IDX_W)
    ) u_rr_pick (
        .req (eligible),
        .ptr (rr_ptr),
        .win (win),
        .any (accept)
    );

    // Encode the one-hot winner into an index and select its pick.
    always_comb begin
        win_idx     = '0;
        accept_pick = '0;
        for (int unsigned p = 0; p < P; p++) begin
            if (win[p]) begin
                win_idx     = IDX_W'(p);
                accept_pick = req_pick[p*N +: N];
            end
        end
    end

    // Decode the last pipeline stage into a one-hot grant.
    always_comb begin
        grant_raw = '0;
        for (int unsigned p = 0; p < P; p++) begin
            if (pipe_vld[GRANT_LAT-1] && pipe_idx[GRANT_LAT-1] == IDX_W'(p)) begin
                grant_raw[p] = 1'b1;
            end
        end
    end

    // Outputs read as reset values during the rst cycle itself, so a grant
    // already sitting in the last stage cannot escape while rst is high.
    assign grant      = rst ? '0 : grant_raw;
    assign grant_pick = (rst || !pipe_vld[GRANT_LAT-1]) ? '0 : pipe_pick[GRANT_LAT-1];
    assign credit_cnt = rst ? CRED_MAX : cnt_q;

    // Round-robin pointer and per-port in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            in_flight <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= IDX_W'((32'(win_idx) + 1) % P);
            end
            in_flight <= (in_flight & ~grant_raw) | win;
        end
    end

    // Returned credits are dropped once the pool is already full.
    assign credit_ret = op_done && (cnt_q != CRED_MAX);

    // Credit counter: accept consumes, op_done returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CRED_MAX;
        end else begin
            case ({accept, credit_ret})
                2'b10:   cnt_q <= cnt_q - CNT_W'(1);
                2'b01:   cnt_q <= cnt_q + CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Latency pipeline valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int unsigned k = 1; k < GRANT_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
            end
        end
    end

    // Latency pipeline payload: winner index and its captured pick.
    always_ff @(posedge clk) begin
        pipe_idx[0]  <= win_idx;
        pipe_pick[0] <= accept_pick;
        for (int unsigned k = 1; k < GRANT_LAT; k++) begin
            pipe_idx[k]  <= pipe_idx[k-1];
            pipe_pick[k] <= pipe_pick[k-1];
        end
    end

endmodule

// File: tb/tb_latent_grant_responder.sv
// Directed bench for latent_grant_responder: default instance plus
// GRANT_LAT=1 and GRANT_LAT=4 instances sharing the same stimulus.
module tb_latent_grant_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_vld;
    logic [15:0] req_pick;
    logic        op_done;

    logic [1:0] g2, g1, g4;
    logic [7:0] gp2, gp1, gp4;
    logic [2:0] cc2, cc1, cc4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    latent_grant_responder dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_pick(req_pick),
        .op_done(op_done), .grant(g2), .grant_pick(gp2), .credit_cnt(cc2)
    );

    latent_grant_responder #(.GRANT_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_pick(req_pick),
        .op_done(op_done), .grant(g1), .grant_pick(gp1), .credit_cnt(cc1)
    );

    latent_grant_responder #(.GRANT_LAT(4)) dut_l4 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_pick(req_pick),
        .op_done(op_done), .grant(g4), .grant_pick(gp4), .credit_cnt(cc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_vld = '0; req_pick = '0; op_done = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_grant", 32'(g2), 0);
        chk("rst_pick", 32'(gp2), 0);
        chk("rst_cnt", 32'(cc2), 2);
        chk("rst_cnt_l4", 32'(cc4), 2);

        // Single request held one cycle; all latencies see the same accept.
        nxt(); rst = 1'b0; req_vld = 2'b01; req_pick = {8'h00, 8'h04};
        @(negedge clk);
        chk("t1_c0_cnt", 32'(cc2), 2);
        chk("t1_c0_g", 32'(g2), 0);
        nxt(); req_vld = 2'b00;
        @(negedge clk);
        chk("t1_c1_cnt", 32'(cc2), 1);
        chk("t1_c1_g", 32'(g2), 0);
        chk("t1_c1_g_l1", 32'(g1), 1);
        chk("t1_c1_p_l1", 32'(gp1), 8'h04);
        chk("t1_c1_g_l4", 32'(g4), 0);
        nxt();
        @(negedge clk);
        chk("t1_c2_g", 32'(g2), 1);
        chk("t1_c2_p", 32'(gp2), 8'h04);
        chk("t1_c2_g_l1", 32'(g1), 0);
        chk("t1_c2_g_l4", 32'(g4), 0);
        nxt();
        @(negedge clk);
        chk("t1_c3_g", 32'(g2), 0);
        chk("t1_c3_p", 32'(gp2), 0);
        chk("t1_c3_g_l1", 32'(g1), 0);
        chk("t1_c3_g_l4", 32'(g4), 0);
        nxt();
        @(negedge clk);
        chk("t1_c4_g_l4", 32'(g4), 1);
        chk("t1_c4_p_l4", 32'(gp4), 8'h04);
        chk("t1_c4_g", 32'(g2), 0);
        nxt();
        @(negedge clk);
        chk("t1_c5_g_l4", 32'(g4), 0);
        chk("t1_c5_cnt_l4", 32'(cc4), 1);
        nxt(); op_done = 1'b1;
        nxt(); op_done = 1'b0;
        @(negedge clk);
        chk("t1_ret_cnt", 32'(cc2), 2);
        chk("t1_ret_cnt_l1", 32'(cc1), 2);
        chk("t1_ret_cnt_l4", 32'(cc4), 2);

        // Contention from a fresh reset, then credit exhaustion.
        nxt(); rst = 1'b1;
        @(negedge clk);
        chk("t2_rst_g", 32'(g2), 0);
        nxt(); rst = 1'b0; req_vld = 2'b11; req_pick = {8'h80, 8'h01};
        @(negedge clk);
        chk("t2_c0_cnt", 32'(cc2), 2);
        nxt();
        @(negedge clk);
        chk("t2_c1_cnt", 32'(cc2), 1);
        chk("t2_c1_g", 32'(g2), 0);
        nxt();
        @(negedge clk);
        chk("t2_c2_cnt", 32'(cc2), 0);
        chk("t2_c2_g", 32'(g2), 2'b01);
        chk("t2_c2_p", 32'(gp2), 8'h01);
        chk("t2_rr_ptr", 32'(dut.rr_ptr), 0);
        nxt(); req_vld = 2'b00;
        @(negedge clk);
        chk("t2_c3_g", 32'(g2), 2'b10);
        chk("t2_c3_p", 32'(gp2), 8'h80);
        nxt(); req_vld = 2'b01; req_pick = {8'h00, 8'h3C};
        @(negedge clk);
        chk("t3_c4_g", 32'(g2), 0);
        chk("t3_c4_p", 32'(gp2), 0);
        chk("t3_c4_cnt", 32'(cc2), 0);
        nxt();
        @(negedge clk);
        chk("t3_c5_g", 32'(g2), 0);
        nxt();
        @(negedge clk);
        chk("t3_c6_g", 32'(g2), 0);
        nxt(); op_done = 1'b1;
        @(negedge clk);
        chk("t3_c7_cnt", 32'(cc2), 0);
        chk("t3_c7_g", 32'(g2), 0);
        nxt(); op_done = 1'b0;
        @(negedge clk);
        chk("t3_c8_cnt", 32'(cc2), 1);
        nxt(); req_vld = 2'b00;
        @(negedge clk);
        chk("t3_c9_cnt", 32'(cc2), 0);
        chk("t3_c9_g", 32'(g2), 0);
        nxt();
        @(negedge clk);
        chk("t3_c10_g", 32'(g2), 2'b01);
        chk("t3_c10_p", 32'(gp2), 8'h3C);

        // Accept with op_done at one credit, then op_done at full credit.
        nxt(); op_done = 1'b1;
        @(negedge clk);
        chk("t4_c11_g", 32'(g2), 0);
        nxt(); req_vld = 2'b10; req_pick = {8'hA5, 8'h00};
        @(negedge clk);
        chk("t4_c12_cnt", 32'(cc2), 1);
        nxt(); op_done = 1'b0; req_vld = 2'b00;
        @(negedge clk);
        chk("t4_c13_cnt", 32'(cc2), 1);
        nxt();
        @(negedge clk);
        chk("t4_c14_g", 32'(g2), 2'b10);
        chk("t4_c14_p", 32'(gp2), 8'hA5);
        nxt(); op_done = 1'b1;
        @(negedge clk);
        chk("t4_c15_cnt", 32'(cc2), 1);
        nxt();
        @(negedge clk);
        chk("t4_c16_cnt", 32'(cc2), 2);
        nxt(); op_done = 1'b0;
        @(negedge clk);
        chk("t4_sat_cnt", 32'(cc2), 2);

        // Reset while an accept is in flight.
        nxt(); req_vld = 2'b01; req_pick = {8'h00, 8'h20};
        @(negedge clk);
        chk("t5_c0_cnt", 32'(cc2), 2);
        nxt(); req_vld = 2'b00; rst = 1'b1;
        @(negedge clk);
        chk("t5_c1_g", 32'(g2), 0);
        chk("t5_c1_g_l1", 32'(g1), 0);
        chk("t5_c1_p_l1", 32'(gp1), 0);
        chk("t5_c1_cnt", 32'(cc2), 2);
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("t5_c2_g", 32'(g2), 0);
        chk("t5_c2_p", 32'(gp2), 0);
        chk("t5_c2_cnt", 32'(cc2), 2);
        nxt();
        @(negedge clk);
        chk("t5_c3_g", 32'(g2), 0);
        nxt();
        @(negedge clk);
        chk("t5_c4_g_l4", 32'(g4), 0);
        chk("t5_c4_p_l4", 32'(gp4), 0);
        chk("t5_c4_cnt_l4", 32'(cc4), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latent_grant_responder.md
LATENT_GRANT_RESPONDER -- requirements
Module: latent_grant_responder

Interface
REQ-001 SHALL have parameter N, default 8: width of the one-hot entry pick vector.
REQ-002 SHALL have parameter P, default 2: number of requesting picker ports.
REQ-003 SHALL have parameter GRANT_LAT, default 2 (legal range 1..4): cycles from accept to grant pulse.
REQ-004 SHALL have parameter CREDITS, default 2 (legal range 1..7): maximum number of accepted-but-not-done operations.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port req_vld, input, P bits: per-port request valid; held high until that port's grant.
REQ-008 SHALL have port req_pick, input, P*N bits: per-port one-hot pick, port p in bits [p*N +: N], held stable while req_vld[p]=1.
REQ-009 SHALL have port op_done, input, 1 bit: one-cycle pulse returning one credit.
REQ-010 SHALL have port grant, output, P bits: one-cycle grant pulse per port.
REQ-011 SHALL have port grant_pick, output, N bits: pick vector of the port granted this cycle, zero otherwise.
REQ-012 SHALL have port credit_cnt, output, 3 bits: credits currently available.

Function
REQ-013 SHALL mark port p eligible when req_vld[p]=1, p is not in flight, and credit_cnt>0.
REQ-014 SHALL accept at most one eligible port per cycle, chosen round-robin starting at rr_ptr.
REQ-015 SHALL advance rr_ptr to (winner+1) mod P on accept; otherwise hold rr_ptr.
REQ-016 SHALL capture the winner's index and req_pick at accept, set its in-flight flag, and shift the pair through a GRANT_LAT-deep pipeline.
REQ-017 SHALL pulse grant[winner] and drive grant_pick=captured pick exactly GRANT_LAT cycles after the accept edge.
REQ-018 SHALL clear the port's in-flight flag in the grant cycle, making the port eligible again no earlier than the next cycle.
REQ-019 SHALL decrement credit_cnt on accept and increment it on op_done; on a simultaneous accept and op_done, credit_cnt SHALL be unchanged.
REQ-020 SHALL ignore op_done while credit_cnt=CREDITS (saturate, no wrap).
REQ-021 SHALL issue no accept while credit_cnt=0, even if op_done is high in the same cycle; the returned credit is usable from the next cycle.
REQ-022 SHALL never assert more than one grant bit in a cycle; grant_pick SHALL be all-zero when grant=0.
REQ-023 SHALL still issue the grant for an accepted request if req_vld drops while in flight (protocol violation; no cancel path).
REQ-024 SHALL NOT check one-hot-ness of req_pick; the captured value is forwarded unchanged.

Reset
REQ-025 SHALL, while rst=1, set grant=0, grant_pick=0, credit_cnt=CREDITS, rr_ptr=0, and clear all in-flight flags and pipeline valids.
REQ-026 SHALL, on rst asserted mid-operation, discard all pending grants; no grant SHALL appear in or after the reset cycle from pre-reset accepts.

Structure
REQ-027 SHALL take the defaults of N, P, GRANT_LAT, and CREDITS, plus the credit-count width, from the shared issue package.
REQ-028 SHALL implement arbitration in one sub-module, rr_pick, with inputs req[P] and ptr and outputs one-hot win[P] and any.
REQ-029 SHALL keep the latency pipeline and credit counter in the top module.

Verification
REQ-030 Single request: P=2, req_vld=01, pick=8'b00000100 at cycle 0 -> grant=01 and grant_pick=00000100 at cycle 2; credit_cnt 2->1.
REQ-031 Contention: req_vld=11 from cycle 0, rr_ptr=0 -> port 0 accepted cycle 0 and granted cycle 2; port 1 accepted cycle 1 and granted cycle 3; rr_ptr=0 after cycle 1.
REQ-032 Credit exhaustion: CREDITS=2, three requests, no op_done -> exactly two grants; third request accepted the cycle after the first op_done pulse.
REQ-033 Simultaneous events: accept and op_done in the same cycle at credit_cnt=1 -> credit_cnt remains 1; op_done at credit_cnt=2 -> credit_cnt remains 2.
REQ-034 Reset mid-flight: accept at cycle 0 with GRANT_LAT=2, rst=1 at cycle 1 -> no grant at cycle 2; credit_cnt=2 after reset.
REQ-035 Latency sweep: GRANT_LAT in {1,4} -> grant appears exactly GRANT_LAT cycles after accept; a port is never granted twice per accept.
